hist_eq_engine: RTL and testbench

//  RAM-based, runtime-sized histogram equaliser. Next generation of the per-level comparator design.

---
 rtl/hist_eq_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_hist_eq_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_engine.sv
// Two-pass histogram equaliser: histogram accumulate, optional clip, CDF/LUT build, then
// per-pixel remap through the LUT held in the same bin RAM, with a 2-entry output skid buffer.
module hist_eq_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PIXELS = 640*480,
    parameter int CNT_WIDTH  = $clog2(MAX_PIXELS+1),
    parameter int SCALE_BITS = 24
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [CNT_WIDTH-1:0]             i_num_pixels,
    input  logic [CNT_WIDTH-1:0]             i_clip_limit,
    input  logic [SCALE_BITS+DATA_WIDTH-1:0] i_scale,
    input  logic [DATA_WIDTH-1:0]            i_pixel,
    input  logic                             i_pixel_valid,
    output logic                             o_pixel_ready,
    output logic [DATA_WIDTH-1:0]            o_pixel,
    output logic                             o_pixel_valid,
    output logic                             o_pixel_last,
    input  logic                             i_pixel_ready,
    output logic                             o_rd_image,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [CNT_WIDTH-1:0]             o_cdf_min
);

    localparam int BINS    = 1 << DATA_WIDTH;
    localparam int SCALE_W = SCALE_BITS + DATA_WIDTH;
    localparam int PROD_W  = CNT_WIDTH + SCALE_W;
    localparam logic [CNT_WIDTH-1:0]  MAX_N    = CNT_WIDTH'(MAX_PIXELS);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH:0]   BIN_ONE  = (DATA_WIDTH+1)'(1);
    localparam logic [DATA_WIDTH:0]   LAST_BIN = (DATA_WIDTH+1)'(BINS - 1);
    localparam logic [DATA_WIDTH-1:0] LUT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_CLIP, S_CDF, S_RDREQ, S_MAP, S_DONE
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_count(input logic [CNT_WIDTH-1:0] n);
        return (n > MAX_N) ? MAX_N : n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] clip_value(input logic [CNT_WIDTH-1:0] h,
                                                        input logic [CNT_WIDTH-1:0] lim);
        return (h > lim) ? lim : h;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] clip_excess(input logic [CNT_WIDTH-1:0] h,
                                                         input logic [CNT_WIDTH-1:0] lim);
        return (h > lim) ? (h - lim) : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_lut(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] q;
        q = prod >> SCALE_BITS;
        if (q > PROD_W'(LUT_MAX))
            return LUT_MAX;
        return q[DATA_WIDTH-1:0];
    endfunction

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]  n_lat, clip_lat;
    logic [SCALE_W-1:0]    scale_lat;
    logic [DATA_WIDTH:0]   bin_cnt;
    logic [CNT_WIDTH-1:0]  in_cnt;

    logic                  vld_p0, last_p0;
    logic [DATA_WIDTH-1:0] addr_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] addr_p1;
    logic [CNT_WIDTH-1:0]  cnt_p1;

    logic [CNT_WIDTH-1:0]  excess, add, cdf, cdf_next, cdf_min_r, cdf_min_eff, hist_base;
    logic                  cdf_min_found;
    logic [PROD_W-1:0]     prod;
    logic [DATA_WIDTH-1:0] lut_val;

    logic [CNT_WIDTH-1:0]  mem [BINS];
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_waddr, ram_raddr;
    logic [CNT_WIDTH-1:0]  ram_wdata, ram_rdata;

    logic [DATA_WIDTH-1:0] sk_data0, sk_data1;
    logic                  sk_last0, sk_last1;
    logic [1:0]            sk_cnt;
    logic [2:0]            occ;
    logic                  walk_issue, in_room, pix_ready, accept, push, pop;

    always_ff @(posedge i_clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    assign walk_issue = ~bin_cnt[DATA_WIDTH];
    assign in_room    = in_cnt < n_lat;
    assign pop        = (sk_cnt != 2'd0) && i_pixel_ready;
    assign push       = (state == S_MAP) && vld_p0;
    // Count the beat in flight from the RAM so an accept can never overflow the skid buffer.
    assign occ        = {1'b0, sk_cnt} + {2'b00, vld_p0} - {2'b00, pop};
    assign pix_ready  = ((state == S_ACCUM) && in_room) ||
                        ((state == S_MAP) && in_room && (occ < 3'd2));
    assign accept     = i_pixel_valid && pix_ready;

    // Stage p0 datapath: RAM read data is valid for addr_p0
    assign hist_base   = (vld_p1 && (addr_p1 == addr_p0)) ? cnt_p1 : ram_rdata;
    assign add         = excess >> DATA_WIDTH;
    assign cdf_next    = cdf + ram_rdata + add;
    assign cdf_min_eff = cdf_min_found ? cdf_min_r : cdf_next;
    assign prod        = PROD_W'(cdf_next - cdf_min_eff) * PROD_W'(scale_lat);
    assign lut_val     = (cdf_next == '0) ? '0 : sat_lut(prod);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr_p0;
        ram_wdata = '0;
        ram_raddr = bin_cnt[DATA_WIDTH-1:0];
        case (state)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = bin_cnt[DATA_WIDTH-1:0];
            end
            S_ACCUM: begin
                ram_raddr = i_pixel;
                ram_we    = vld_p0;
                ram_wdata = hist_base + CNT_ONE;
            end
            S_CLIP: begin
                ram_we    = vld_p0;
                ram_wdata = clip_value(ram_rdata, clip_lat);
            end
            S_CDF: begin
                ram_we    = vld_p0;
                ram_wdata = CNT_WIDTH'(lut_val);
            end
            S_MAP:   ram_raddr = i_pixel;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = (sat_count(i_num_pixels) == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: if (bin_cnt == LAST_BIN) state_nxt = S_ACCUM;
            S_ACCUM: if (!in_room && !vld_p0) state_nxt = (clip_lat != '0) ? S_CLIP : S_CDF;
            S_CLIP:  if (!walk_issue && !vld_p0) state_nxt = S_CDF;
            S_CDF:   if (!walk_issue && !vld_p0) state_nxt = S_RDREQ;
            S_RDREQ: state_nxt = S_MAP;
            S_MAP:   if (pop && sk_last0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            bin_cnt       <= '0;
            in_cnt        <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            sk_cnt        <= 2'd0;
            cdf_min_found <= 1'b0;
            o_cdf_min     <= '0;
        end else begin
            state <= state_nxt;
            if (state != state_nxt)
                bin_cnt <= '0;
            else if ((state == S_CLEAR) || (walk_issue && ((state == S_CLIP) || (state == S_CDF))))
                bin_cnt <= bin_cnt + BIN_ONE;
            if (state != state_nxt)
                in_cnt <= '0;
            else if (accept)
                in_cnt <= in_cnt + CNT_ONE;
            vld_p0 <= accept || (walk_issue && ((state == S_CLIP) || (state == S_CDF)));
            vld_p1 <= (state == S_ACCUM) && vld_p0;
            case ({push, pop})
                2'b10:   sk_cnt <= sk_cnt + 2'd1;
                2'b01:   sk_cnt <= sk_cnt - 2'd1;
                default: ;
            endcase
            if (state != S_CDF)
                cdf_min_found <= 1'b0;
            else if (vld_p0 && (cdf_next != '0))
                cdf_min_found <= 1'b1;
            if ((state == S_CDF) && (state_nxt == S_RDREQ))
                o_cdf_min <= cdf_min_r;
        end
    end

    // Stage p0 -> p1 boundary and frame datapath registers
    always_ff @(posedge i_clk) begin
        if ((state == S_IDLE) && i_start) begin
            n_lat     <= sat_count(i_num_pixels);
            clip_lat  <= i_clip_limit;
            scale_lat <= i_scale;
        end
        addr_p0 <= ram_raddr;
        last_p0 <= (in_cnt == n_lat - CNT_ONE);
        addr_p1 <= addr_p0;
        cnt_p1  <= ram_wdata;
        if (state == S_IDLE)
            excess <= '0;
        else if ((state == S_CLIP) && vld_p0)
            excess <= excess + clip_excess(ram_rdata, clip_lat);
        if (state != S_CDF)
            cdf <= '0;
        else if (vld_p0)
            cdf <= cdf_next;
        if ((state == S_CDF) && vld_p0 && !cdf_min_found && (cdf_next != '0))
            cdf_min_r <= cdf_next;
        case ({push, pop})
            2'b10: begin
                if (sk_cnt == 2'd0) begin
                    sk_data0 <= ram_rdata[DATA_WIDTH-1:0];
                    sk_last0 <= last_p0;
                end else begin
                    sk_data1 <= ram_rdata[DATA_WIDTH-1:0];
                    sk_last1 <= last_p0;
                end
            end
            2'b01: begin
                sk_data0 <= sk_data1;
                sk_last0 <= sk_last1;
            end
            2'b11: begin
                if (sk_cnt == 2'd1) begin
                    sk_data0 <= ram_rdata[DATA_WIDTH-1:0];
                    sk_last0 <= last_p0;
                end else begin
                    sk_data0 <= sk_data1;
                    sk_last0 <= sk_last1;
                    sk_data1 <= ram_rdata[DATA_WIDTH-1:0];
                    sk_last1 <= last_p0;
                end
            end
            default: ;
        endcase
    end

    assign o_pixel_ready = pix_ready;
    assign o_pixel_valid = (sk_cnt != 2'd0);
    assign o_pixel       = o_pixel_valid ? sk_data0 : '0;
    assign o_pixel_last  = o_pixel_valid && sk_last0;
    assign o_rd_image    = (state == S_RDREQ);
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);

endmodule

// File: tb/tb_hist_eq_engine.sv
// Directed bench for hist_eq_engine: an 8-bit instance for the main frames and a 2-bit instance
// for the clip-limit case, sharing the pixel stream and selected through use_b.
module tb_hist_eq_engine;

    logic        clk, rst, start_a, start_b, use_b;
    logic [18:0] num, clip;
    logic [31:0] scale;
    logic [7:0]  pix;
    logic        pvld, drdy;

    logic        a_prdy, a_pvld, a_last, a_rd, a_busy, a_done;
    logic [7:0]  a_pix;
    logic [18:0] a_cdf;
    logic        b_prdy, b_pvld, b_last, b_rd, b_busy, b_done;
    logic [1:0]  b_pix;
    logic [6:0]  b_cdf;
    logic [6:0]  b_num, b_clip;
    logic [25:0] b_scale;

    logic        o_prdy, o_pvld, o_last, o_rd, o_done;
    logic [7:0]  o_pix;
    logic [18:0] o_cdf;

    int n_assert, n_fail, done_cnt_a, rd_cnt_a;
    int in_px[64], map_px[64], exp_px[64];
    int done_base, rd_base;

    assign b_num   = num[6:0];
    assign b_clip  = clip[6:0];
    assign b_scale = scale[25:0];

    hist_eq_engine dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_num_pixels(num), .i_clip_limit(clip),
        .i_scale(scale), .i_pixel(pix), .i_pixel_valid(pvld), .o_pixel_ready(a_prdy),
        .o_pixel(a_pix), .o_pixel_valid(a_pvld), .o_pixel_last(a_last), .i_pixel_ready(drdy),
        .o_rd_image(a_rd), .o_busy(a_busy), .o_done(a_done), .o_cdf_min(a_cdf)
    );

    hist_eq_engine #(.DATA_WIDTH(2), .MAX_PIXELS(64)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_num_pixels(b_num), .i_clip_limit(b_clip),
        .i_scale(b_scale), .i_pixel(pix[1:0]), .i_pixel_valid(pvld), .o_pixel_ready(b_prdy),
        .o_pixel(b_pix), .o_pixel_valid(b_pvld), .o_pixel_last(b_last), .i_pixel_ready(drdy),
        .o_rd_image(b_rd), .o_busy(b_busy), .o_done(b_done), .o_cdf_min(b_cdf)
    );

    always_comb begin
        if (use_b) begin
            o_prdy = b_prdy; o_pvld = b_pvld; o_last = b_last; o_rd = b_rd; o_done = b_done;
            o_pix  = {6'b0, b_pix};
            o_cdf  = {12'b0, b_cdf};
        end else begin
            o_prdy = a_prdy; o_pvld = a_pvld; o_last = a_last; o_rd = a_rd; o_done = a_done;
            o_pix  = a_pix;
            o_cdf  = a_cdf;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_done) done_cnt_a <= done_cnt_a + 1;
        if (a_rd)   rd_cnt_a   <= rd_cnt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic run_frame(input bit sel_b, input int n, input int stall_at, input int stall_len,
                             input bit spam_start, input int exp_cdf, input string tag);
        int idx, oidx, cyc;
        bit seen, low_seen;
        use_b = sel_b;
        @(posedge clk); #1;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        pvld = 1'b1; pix = 8'(in_px[0]); idx = 0; cyc = 0;
        while (idx < n && cyc < 3000) begin
            @(negedge clk);
            if (pvld && o_prdy) idx++;
            @(posedge clk); #1;
            if (!spam_start) begin start_a = 1'b0; start_b = 1'b0; end
            pvld = (idx < n);
            pix  = 8'(in_px[(idx < n) ? idx : 0]);
            cyc++;
        end
        pvld = 1'b0;
        chk({tag, " pass1 accepted"}, 32'(idx), 32'(n));
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            seen = o_rd;
            cyc++;
        end
        start_a = 1'b0; start_b = 1'b0;
        chk({tag, " rd_image"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        idx = 0; oidx = 0; cyc = 0; low_seen = 1'b0;
        pvld = 1'b1; pix = 8'(map_px[0]);
        drdy = !(stall_len > 0 && stall_at == 0);
        while (oidx < n && cyc < 3000) begin
            @(negedge clk);
            if (!drdy && pvld && !o_prdy) low_seen = 1'b1;
            if (pvld && o_prdy) idx++;
            if (o_pvld && drdy) begin
                chk($sformatf("%s beat%0d pixel", tag, oidx), 32'(o_pix), 32'(exp_px[oidx]));
                chk($sformatf("%s beat%0d last", tag, oidx), 32'(o_last), 32'(oidx == n - 1));
                oidx++;
            end
            @(posedge clk); #1;
            cyc++;
            pvld = (idx < n);
            pix  = 8'(map_px[(idx < n) ? idx : 0]);
            drdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
        end
        drdy = 1'b1; pvld = 1'b0;
        chk({tag, " beats out"}, 32'(oidx), 32'(n));
        if (stall_len > 0)
            chk({tag, " ready dropped in stall"}, 32'(low_seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = o_done;
        end
        chk({tag, " done"}, 32'(seen), 32'd1);
        chk({tag, " cdf_min"}, 32'(o_cdf), 32'(exp_cdf));
    endtask

    task automatic setup_ramp;
        for (int k = 0; k < 16; k++) begin
            in_px[k]  = k;
            map_px[k] = 15 - k;
            exp_px[k] = ((15 - k) * 255) / 16;
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0; done_cnt_a = 0; rd_cnt_a = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; use_b = 1'b0;
        num = '0; clip = '0; scale = '0; pix = '0; pvld = 1'b0; drdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(a_busy), 32'd0);
        chk("reset done", 32'(a_done), 32'd0);
        chk("reset rd_image", 32'(a_rd), 32'd0);
        chk("reset out valid", 32'(a_pvld), 32'd0);
        chk("reset in ready", 32'(a_prdy), 32'd0);
        chk("reset pixel", 32'(a_pix), 32'd0);
        chk("reset last", 32'(a_last), 32'd0);
        chk("reset cdf_min", 32'(a_cdf), 32'd0);
        rst = 1'b0;

        // Ramp 0..15, no clipping; pass 2 replays it reversed.
        num = 19'd16; clip = '0; scale = 32'd267386880;
        setup_ramp();
        run_frame(1'b0, 16, 0, 0, 1'b0, 1, "t1");

        // Sixteen back-to-back 7s, start held high through accumulation.
        for (int k = 0; k < 16; k++) begin
            in_px[k] = 7; map_px[k] = k; exp_px[k] = 0;
        end
        run_frame(1'b0, 16, 0, 0, 1'b1, 16, "t2");

        // Two-bit instance with clip limit 4: lut = [0,1,1,2].
        num = 19'd16; clip = 19'd4; scale = 32'd3145728;
        for (int k = 0; k < 16; k++) begin
            in_px[k]  = 1;
            map_px[k] = k % 4;
            case (k % 4)
                0: exp_px[k] = 0;
                1: exp_px[k] = 1;
                2: exp_px[k] = 1;
                default: exp_px[k] = 2;
            endcase
        end
        run_frame(1'b1, 16, 0, 0, 1'b0, 3, "t3");

        // Ramp again with a five-cycle downstream stall.
        num = 19'd16; clip = '0; scale = 32'd267386880;
        setup_ramp();
        run_frame(1'b0, 16, 4, 5, 1'b0, 1, "t4");

        // Empty frame goes straight to DONE without a second read.
        use_b = 1'b0;
        @(posedge clk); #1;
        num = '0; start_a = 1'b1; rd_base = rd_cnt_a; done_base = done_cnt_a;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("t5 done pulse", 32'(a_done), 32'd1);
        @(posedge clk); #1;
        chk("t5 done cleared", 32'(a_done), 32'd0);
        chk("t5 idle", 32'(a_busy), 32'd0);
        chk("t5 no rd_image", 32'(rd_cnt_a), 32'(rd_base));
        chk("t5 single done", 32'(done_cnt_a), 32'(done_base + 1));

        // Abort mid-accumulation, then a clean ramp frame.
        num = 19'd16; clip = '0; scale = 32'd267386880;
        start_a = 1'b1; pvld = 1'b1; pix = '0;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (260) @(posedge clk);
        #1;
        chk("t6 busy before reset", 32'(a_busy), 32'd1);
        rst = 1'b1; done_base = done_cnt_a;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; pvld = 1'b0;
        chk("t6 busy after reset", 32'(a_busy), 32'd0);
        chk("t6 ready after reset", 32'(a_prdy), 32'd0);
        chk("t6 cdf_min after reset", 32'(a_cdf), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t6 no done on abort", 32'(done_cnt_a), 32'(done_base));
        setup_ramp();
        run_frame(1'b0, 16, 0, 0, 1'b0, 1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
